// File: rtl/cmd_pkg.sv
// -----------------------------------------------------------------------------
// cmd_pkg
// Shared definitions for the byte-oriented command parser:
//   - state_e        : parser FSM states
//   - ADDR_W_DEF     : default register address width
//   - DATA_W_DEF     : default byte/data width
//   - TIMEOUT_DEF    : default idle-cycle limit between command and data byte
//   - WR_FLAG_BIT    : bit of the command byte that selects write (1) or read (0)
//   - cnt_width()    : width needed to hold 0..max_val without wrapping
// -----------------------------------------------------------------------------
package cmd_pkg;

    localparam int ADDR_W_DEF  = 7;
    localparam int DATA_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 255;
    localparam int WR_FLAG_BIT = 7;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_DATA  = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ      = 3'd3,
        ST_READ_WAIT = 3'd4,
        ST_SEND      = 3'd5
    } state_e;

    // Width of a counter that must reach max_val; at least one bit.
    function automatic int cnt_width(input int max_val);
        int w;
        if (max_val < 1) begin
            w = 1;
        end else begin
            w = $clog2(max_val + 1);
        end
        return w;
    endfunction

endpackage

// File: rtl/cmd_timer.sv
// -----------------------------------------------------------------------------
// cmd_timer
// Idle-cycle counter used while the parser waits for a data byte.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-low reset
//   clear_i   : force the count to zero (held while the parser is not waiting)
//   enable_i  : count one idle cycle
//   expired_o : registered flag, high while the count sits at TIMEOUT-1, i.e.
//               the next enabled cycle is the one that reaches TIMEOUT
// The counter saturates at TIMEOUT and never wraps.
// -----------------------------------------------------------------------------
module cmd_timer
    import cmd_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int            CW       = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_last_q;
    logic          at_last_d;

    // Next count: clear has priority, then saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        // Registering the "one step from TIMEOUT" compare keeps the expiry
        // decision in the parser free of the counter's adder path.
        at_last_d = (cnt_d == CNT_LAST);
    end

    // Counter and expiry flag registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q     <= '0;
            at_last_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            at_last_q <= at_last_d;
        end
    end

    assign expired_o = at_last_q;

endmodule

// File: rtl/cmd_parser.sv
// -----------------------------------------------------------------------------
// cmd_parser
// Turns a stream of received bytes into register-decoder accesses.
//   Command byte: bit 7 = 1 -> write (a data byte follows), 0 -> read.
//                 Low ADDR_W bits = register address.
//   Write: the data byte is presented on w_data with a one-cycle wr strobe.
//   Read : one-cycle rd strobe, r_data captured the cycle after, then sent
//          back on tx_data/tx_valid until the transmitter takes it.
//   A write command with no data byte within TIMEOUT cycles is abandoned
//   with a one-cycle err_timeout pulse.
// Ports:
//   clk, rst            : clock (rising edge), synchronous active-low reset
//   rx_data/valid/ready : byte input handshake
//   address, w_data     : decoder address / write data (held between commands)
//   wr, rd              : one-cycle decoder strobes
//   r_data              : decoder read data, valid the cycle after rd
//   tx_data/valid/ready : response byte handshake
//   busy                : high whenever the parser is not idle
//   err_timeout         : one-cycle pulse on data-byte timeout
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module cmd_parser
    import cmd_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] w_data,
    output logic              wr,
    output logic              rd,
    input  logic [DATA_W-1:0] r_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              err_timeout
);

    state_e            state_q,    state_d;
    logic [ADDR_W-1:0] address_q,  address_d;
    logic [DATA_W-1:0] w_data_q,   w_data_d;
    logic [DATA_W-1:0] tx_data_q,  tx_data_d;
    logic              wr_q,       wr_d;
    logic              rd_q,       rd_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q,     busy_d;
    logic              rx_ready_q, rx_ready_d;
    logic              err_q,      err_d;

    logic              accept_s;
    logic              tmr_clear_s;
    logic              tmr_enable_s;
    logic              tmr_expired_s;

    assign accept_s     = rx_valid && rx_ready_q;
    // Holding the timer clear outside GET_DATA guarantees a zero count on entry.
    assign tmr_clear_s  = (state_q != ST_GET_DATA);
    assign tmr_enable_s = (state_q == ST_GET_DATA) && !accept_s;

    cmd_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (tmr_clear_s),
        .enable_i  (tmr_enable_s),
        .expired_o (tmr_expired_s)
    );

    // Next-state, datapath loads and next output values.
    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        w_data_d  = w_data_q;
        tx_data_d = tx_data_q;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    address_d = rx_data[ADDR_W-1:0];
                    if (rx_data[WR_FLAG_BIT]) begin
                        state_d = ST_GET_DATA;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GET_DATA: begin
                // A byte arriving on the expiry cycle takes priority.
                if (accept_s) begin
                    w_data_d = rx_data;
                    state_d  = ST_WRITE;
                end else if (tmr_expired_s) begin
                    err_d    = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_GET_DATA;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_READ: begin
                state_d = ST_READ_WAIT;
            end
            ST_READ_WAIT: begin
                tx_data_d = r_data;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        wr_d       = (state_d == ST_WRITE);
        rd_d       = (state_d == ST_READ);
        tx_valid_d = (state_d == ST_SEND);
        busy_d     = (state_d != ST_IDLE);
        rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_GET_DATA);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            address_q  <= '0;
            w_data_q   <= '0;
            tx_data_q  <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            rx_ready_q <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            address_q  <= address_d;
            w_data_q   <= w_data_d;
            tx_data_q  <= tx_data_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            rx_ready_q <= rx_ready_d;
            err_q      <= err_d;
        end
    end

    assign rx_ready    = rx_ready_q;
    assign address     = address_q;
    assign w_data      = w_data_q;
    assign wr          = wr_q;
    assign rd          = rd_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_cmd_parser
// Transaction-level reference model (timestamps of command/data accepts)
// compared against every output on every falling edge, plus directed
// scenarios with literal expectations, followed by randomized traffic.
// Edge numbering: a byte accepted at rising edge k gives wr/rd visible after
// edge k (data/command edge), tx_valid after edge k+2, timeout after edge
// cmd+TIMEOUT.
// -----------------------------------------------------------------------------
module tb_cmd_parser;

    localparam int T = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [6:0] address;
    logic [7:0] w_data;
    logic       wr;
    logic       rd;
    logic [7:0] r_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cmd_parser #(
        .ADDR_W  (7),
        .DATA_W  (8),
        .TIMEOUT (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .address     (address),
        .w_data      (w_data),
        .wr          (wr),
        .rd          (rd),
        .r_data      (r_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         k       = 0;
    bit         m_wait  = 1'b0;   // write command accepted, data byte pending
    bit         m_read  = 1'b0;   // read in flight until response handed off
    int         m_cmd_k = 0;
    int         m_rd_k  = 0;
    int         m_wr_k  = -100;
    int         m_err_k = -100;
    logic [6:0] m_addr  = 7'h00;
    logic [7:0] m_wdata = 8'h00;
    logic [7:0] m_tx    = 8'h00;
    bit         model_on = 1'b0;

    bit         e_wr, e_rd, e_err, e_txv, e_rxr, e_busy;

    initial begin
        bit acc;
        e_rxr = 1'b1;
        forever begin
            @(posedge clk);
            k++;
            if (rst !== 1'b1) begin
                m_wait  = 1'b0;
                m_read  = 1'b0;
                m_wr_k  = -100;
                m_err_k = -100;
                m_addr  = 7'h00;
                m_wdata = 8'h00;
                m_tx    = 8'h00;
            end else begin
                acc = rx_valid && e_rxr;
                if (m_wait) begin
                    if (acc) begin
                        m_wdata = rx_data;
                        m_wr_k  = k;
                        m_wait  = 1'b0;
                    end else if (k == m_cmd_k + T) begin
                        m_err_k = k;
                        m_wait  = 1'b0;
                    end
                end else if (m_read) begin
                    if (k == m_rd_k + 2) begin
                        m_tx = r_data;
                    end else if (k > m_rd_k + 2 && tx_ready) begin
                        m_read = 1'b0;
                    end
                end else if (acc) begin
                    m_addr = rx_data[6:0];
                    if (rx_data[7]) begin
                        m_wait  = 1'b1;
                        m_cmd_k = k;
                    end else begin
                        m_read = 1'b1;
                        m_rd_k = k;
                    end
                end
            end
            e_wr     = (m_wr_k == k);
            e_rd     = m_read && (m_rd_k == k);
            e_err    = (m_err_k == k);
            e_txv    = m_read && (k >= m_rd_k + 2);
            e_rxr    = !m_read && !e_wr;
            e_busy   = m_wait || m_read || e_wr;
            model_on = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                chk("cyc_wr",       wr,          e_wr);
                chk("cyc_rd",       rd,          e_rd);
                chk("cyc_err",      err_timeout, e_err);
                chk("cyc_tx_valid", tx_valid,    e_txv);
                chk("cyc_rx_ready", rx_ready,    e_rxr);
                chk("cyc_busy",     busy,        e_busy);
                chk("cyc_address",  address,     m_addr);
                chk("cyc_w_data",   w_data,      m_wdata);
                if (e_txv) begin
                    chk("cyc_tx_data", tx_data, m_tx);
                end
                if (!m_read && !e_txv && rst === 1'b1 && k > 0 && m_tx == 8'h00) begin
                    chk("cyc_tx_data_idle0", tx_data, m_tx);
                end
            end
        end
    end

    // Drive one cycle of inputs, return 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [7:0] d, input logic tr, input logic [7:0] rdat);
        rx_valid = v;
        rx_data  = d;
        tx_ready = tr;
        r_data   = rdat;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pct;
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        r_data   = 8'h00;
        repeat (3) step(1'b1, 8'h85, 1'b1, 8'hFF);
        chk("rst_busy",     busy,     1'b0);
        chk("rst_rx_ready", rx_ready, 1'b1);
        chk("rst_address",  address,  7'h00);
        chk("rst_w_data",   w_data,   8'h00);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_wr",       wr,       1'b0);
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0, 8'h00);
        chk("rel_rx_ready", rx_ready, 1'b1);

        // Write 0x85, 0x3C back-to-back
        step(1'b1, 8'h85, 1'b0, 8'h00);
        step(1'b1, 8'h3C, 1'b0, 8'h00);
        chk("wr_strobe",   wr,       1'b1);
        chk("wr_model",    e_wr,     1'b1);
        chk("wr_address",  address,  7'h05);
        chk("wr_w_data",   w_data,   8'h3C);
        chk("wr_tx_valid", tx_valid, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'h00);
        chk("wr_once",     wr,       1'b0);
        chk("wr_idle_rdy", rx_ready, 1'b1);

        // Read 0x12, r_data 0xA7 in the cycle after rd, then backpressure
        step(1'b1, 8'h12, 1'b0, 8'h00);
        chk("rd_strobe",  rd,      1'b1);
        chk("rd_model",   e_rd,    1'b1);
        chk("rd_address", address, 7'h12);
        step(1'b1, 8'h55, 1'b0, 8'h5A);
        chk("rd_once",     rd,       1'b0);
        chk("rd_wait_txv", tx_valid, 1'b0);
        step(1'b1, 8'h55, 1'b0, 8'hA7);
        chk("rd_txv",      tx_valid, 1'b1);
        chk("rd_tx_data",  tx_data,  8'hA7);
        chk("rd_model_tx", m_tx,     8'hA7);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'h55, 1'b0, 8'(i));
            chk("bp_txv",     tx_valid, 1'b1);
            chk("bp_tx_data", tx_data,  8'hA7);
            chk("bp_rx_rdy",  rx_ready, 1'b0);
        end
        step(1'b0, 8'h00, 1'b1, 8'h00);
        chk("bp_done_txv",  tx_valid, 1'b0);
        chk("bp_done_busy", busy,     1'b0);
        chk("bp_done_rdy",  rx_ready, 1'b1);

        // Timeout after 0x81, then 0x02 is a read
        step(1'b1, 8'h81, 1'b0, 8'h00);
        repeat (T - 1) step(1'b0, 8'h00, 1'b0, 8'h00);
        chk("to_not_yet", err_timeout, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'h00);
        chk("to_err",    err_timeout, 1'b1);
        chk("to_model",  e_err,       1'b1);
        chk("to_no_wr",  wr,          1'b0);
        chk("to_w_data", w_data,      8'h3C);
        chk("to_busy",   busy,        1'b0);
        step(1'b1, 8'h02, 1'b0, 8'h00);
        chk("to_err_once", err_timeout, 1'b0);
        chk("to_next_rd",  rd,          1'b1);
        chk("to_next_adr", address,     7'h02);
        repeat (3) step(1'b0, 8'h00, 1'b1, 8'h00);
        chk("to_next_idle", busy, 1'b0);

        // Data byte on the exact expiry cycle
        step(1'b1, 8'h8A, 1'b0, 8'h00);
        repeat (T - 1) step(1'b0, 8'h00, 1'b0, 8'h00);
        step(1'b1, 8'h99, 1'b0, 8'h00);
        chk("bnd_wr",     wr,          1'b1);
        chk("bnd_no_err", err_timeout, 1'b0);
        chk("bnd_w_data", w_data,      8'h99);
        chk("bnd_addr",   address,     7'h0A);
        step(1'b0, 8'h00, 1'b0, 8'h00);
        chk("bnd_no_err2", err_timeout, 1'b0);

        // Reset while waiting for data
        step(1'b1, 8'h83, 1'b0, 8'h00);
        rst = 1'b0;
        step(1'b1, 8'h44, 1'b0, 8'h00);
        chk("rg_busy",   busy,        1'b0);
        chk("rg_wr",     wr,          1'b0);
        chk("rg_err",    err_timeout, 1'b0);
        chk("rg_addr",   address,     7'h00);
        chk("rg_w_data", w_data,      8'h00);
        chk("rg_rdy",    rx_ready,    1'b1);
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0, 8'h00);
        chk("rg_wr_after", wr, 1'b0);

        // Reset while a response is pending
        step(1'b1, 8'h11, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b0, 8'h44);
        step(1'b0, 8'h00, 1'b0, 8'h44);
        chk("rs_txv_pre", tx_valid, 1'b1);
        chk("rs_txd_pre", tx_data,  8'h44);
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b1, 8'h00);
        chk("rs_txv",  tx_valid, 1'b0);
        chk("rs_txd",  tx_data,  8'h00);
        chk("rs_rd",   rd,       1'b0);
        chk("rs_busy", busy,     1'b0);
        chk("rs_rdy",  rx_ready, 1'b1);
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0, 8'h00);

        // Randomized traffic: varying byte density exercises timeouts too
        for (int seg = 0; seg < 30; seg++) begin
            case ($urandom_range(0, 2))
                0:       pct = 4;
                1:       pct = 50;
                default: pct = 90;
            endcase
            for (int i = 0; i < 100; i++) begin
                rst = ($urandom_range(0, 299) != 0);
                step(($urandom_range(0, 99) < pct), 8'($urandom),
                     ($urandom_range(0, 2) == 0), 8'($urandom));
            end
        end
        rst = 1'b1;
        repeat (4) step(1'b0, 8'h00, 1'b1, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
